// File: rtl/mux_sel_sequencer_pkg.sv
// mux_sel_sequencer_pkg: FSM state encodings and mux channel codes shared by the select sequencer.
package mux_sel_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2
    } state_t;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

endpackage

// File: rtl/mux_sel_next_ch.sv
// mux_sel_next_ch: finds the next enabled channel above cur, else wraps to the lowest enabled one.
module mux_sel_next_ch
    import mux_sel_sequencer_pkg::*;
(
    input  logic [1:0] cur,
    input  logic [3:0] mask,
    output logic [1:0] nxt,
    output logic       wrap,
    output logic       none
);

    always_comb begin
        nxt  = CH_A;
        wrap = 1'b1;
        none = ~|mask;
        for (int i = 3; i >= 0; i--)
            if (mask[i]) nxt = 2'(i);
        // descending scan: the last hit is the lowest enabled index above cur
        for (int i = 3; i >= 0; i--)
            if (mask[i] && i > int'(cur)) begin
                nxt  = 2'(i);
                wrap = 1'b0;
            end
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: steps the 4-to-1 mux select through settle/dwell windows per channel.
// Optional channel masking via SEL_SEQ_MASK_EN (adds the ch_mask port).
module mux_sel_sequencer
    import mux_sel_sequencer_pkg::*;
#(
    parameter int DWELL_CYC  = 4,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       hold,
`ifdef SEL_SEQ_MASK_EN
    input  logic [3:0] ch_mask,
`endif
    output logic       s1,
    output logic       s0,
    output logic       ch_valid,
    output logic       busy,
    output logic       sweep_done
);

    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC > 0 ? SETTLE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] DW_LAST  = CNT_W'(DWELL_CYC - 1);
    localparam state_t           ST_LOAD  = (SETTLE_CYC > 0) ? ST_SETTLE : ST_DWELL;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       sel, sel_nxt, adv_nxt;
    logic [3:0]       mask_live, mask_adv;
    logic             adv_wrap, adv_none, wend, last_nxt;
    logic             valid_d, busy_d, done_d;

`ifdef SEL_SEQ_MASK_EN
    logic [3:0] mask_q;
    // advance decision reuses the mask captured when the final dwell cycle began,
    // so sweep_done and the actual advance always agree
    assign mask_live = ch_mask;
    assign mask_adv  = (state == ST_IDLE) ? ch_mask : mask_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mask_q <= '0;
        else if (!hold && last_nxt) mask_q <= ch_mask;
`else
    assign mask_live = 4'hF;
    assign mask_adv  = 4'hF;
`endif

    mux_sel_next_ch u_next (
        .cur  ((state == ST_IDLE) ? CH_D : sel),
        .mask (mask_adv),
        .nxt  (adv_nxt),
        .wrap (adv_wrap),
        .none (adv_none)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sel        <= CH_A;
            ch_valid   <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            ch_valid   <= valid_d;
            busy       <= busy_d;
            sweep_done <= done_d;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        wend      = (state == ST_SETTLE && cnt == SET_LAST) || (state == ST_DWELL && cnt == DW_LAST);
        if (!hold) begin
            if (state == ST_IDLE && start && !adv_none) begin
                state_nxt = ST_LOAD;
                sel_nxt   = adv_nxt;
            end else if (state == ST_SETTLE && wend) begin
                state_nxt = ST_DWELL;
            end else if (state == ST_DWELL && wend) begin
                if (!adv_none && (!adv_wrap || cont)) begin
                    state_nxt = ST_LOAD;
                    sel_nxt   = adv_nxt;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        end
        cnt_nxt = hold ? cnt :
                  (state_nxt != state || wend || state == ST_IDLE) ? '0 : cnt + CNT_W'(1);
    end

    // outputs are registered, so sweep_done is predicted for the cycle about to start
    always_comb begin
        valid_d  = state_nxt == ST_DWELL;
        busy_d   = state_nxt != ST_IDLE;
        last_nxt = state_nxt == ST_DWELL && cnt_nxt == DW_LAST;
        done_d   = !hold && last_nxt && ~|((mask_live >> sel_nxt) >> 1);
    end

    assign {s1, s0} = sel;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer: table-driven sweep checks with a per-cycle scoreboard plus reset/ignore corner cases.
module tb_mux_sel_sequencer;

    typedef struct packed {
        logic [1:0] sel;
        logic       valid;
        logic       busy;
        logic       done;
    } out_t;

    typedef struct {
        bit         use0;
        bit         cont;
        logic [3:0] mask;
        int         h;
        int         l;
        int         rs;
        int         n;
        string      name;
    } vec_t;

    logic       clk = 0, rst_n = 0, start = 0, start0 = 0, cont = 0, hold = 0;
    logic [3:0] ch_mask = 4'hF;
    logic       s1, s0, ch_valid, busy, sweep_done;
    logic       z1, z0, zv, zb, zd;
    out_t       sb[$];
    vec_t       vecs[$];
    int         n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    mux_sel_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .hold(hold),
`ifdef SEL_SEQ_MASK_EN
        .ch_mask(ch_mask),
`endif
        .s1(s1), .s0(s0), .ch_valid(ch_valid), .busy(busy), .sweep_done(sweep_done)
    );

    mux_sel_sequencer #(.SETTLE_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .cont(cont), .hold(hold),
`ifdef SEL_SEQ_MASK_EN
        .ch_mask(ch_mask),
`endif
        .s1(z1), .s0(z0), .ch_valid(zv), .busy(zb), .sweep_done(zd)
    );

    // expected output at sample k (k=1 is the cycle right after the start edge)
    function automatic out_t model(vec_t r, int k);
        int   s, p, nc, held, v, w, tot;
        int   chans[4];
        logic hn;
        out_t o;
        s = r.use0 ? 0 : 1;
        p = s + 4;
        nc = 0;
        held = 0;
        for (int i = 0; i < 4; i++) if (r.mask[i]) begin chans[nc] = i; nc++; end
        for (int j = 1; j < k; j++) if (j >= r.h && j < r.h + r.l) held++;
        v   = k - held;
        tot = nc * p;
        hn  = (k - 1 >= r.h) && (k - 1 < r.h + r.l);
        if (!r.cont && v > tot) begin
            o = '0;
            o.sel = 2'(chans[nc-1]);
        end else begin
            w       = (v - 1) % tot;
            o.sel   = 2'(chans[w / p]);
            o.valid = (w % p) >= s;
            o.busy  = 1'b1;
            o.done  = (w == tot - 1) && !hn;
        end
        return o;
    endfunction

    function automatic out_t act(bit use0);
        return use0 ? {z1, z0, zv, zb, zd} : {s1, s0, ch_valid, busy, sweep_done};
    endfunction

    task automatic check(string name, out_t got, out_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got sel=%0d valid=%b busy=%b done=%b, expected sel=%0d valid=%b busy=%b done=%b",
                     name, got.sel, got.valid, got.busy, got.done, exp.sel, exp.valid, exp.busy, exp.done);
        end
    endtask

    task automatic check_bit(string name, logic got, logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic wait_idle(string name);
        for (int i = 0; i < 80; i++) begin
            if (!busy && !zb) break;
            @(negedge clk);
        end
        check_bit({name, " idle-timeout"}, busy | zb, 1'b0);
    endtask

    task automatic pulse_start(bit use0);
        @(negedge clk);
        if (use0) start0 = 1; else start = 1;
        @(posedge clk);
        #1 start = 0; start0 = 0;
    endtask

    task automatic run_vec(vec_t r);
        cont    = r.cont;
        ch_mask = r.mask;
        pulse_start(r.use0);
        for (int k = 1; k <= r.n; k++) sb.push_back(model(r, k));
        for (int k = 1; k <= r.n; k++) begin
            @(negedge clk);
            check($sformatf("%s[%0d]", r.name, k), act(r.use0), sb.pop_front());
            hold = (k >= r.h) && (k < r.h + r.l);
            if (r.use0) start0 = (k == r.rs); else start = (k == r.rs);
        end
        hold = 0; start = 0; start0 = 0; cont = 0;
        wait_idle(r.name);
    endtask

    initial begin
        #200000;
        $display("FAIL global-timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs.push_back('{0, 0, 4'hF, -100, 0, -1, 24, "single"});
        vecs.push_back('{0, 1, 4'hF, -100, 0, -1, 45, "continuous"});
        vecs.push_back('{0, 0, 4'hF, 7, 3, -1, 27, "hold_dwell_b"});
        vecs.push_back('{0, 0, 4'hF, 20, 2, -1, 25, "hold_final"});
        vecs.push_back('{1, 0, 4'hF, -100, 0, 5, 18, "settle0_restart"});
        vecs.push_back('{0, 0, 4'hF, -100, 0, 8, 24, "restart_busy"});
`ifdef SEL_SEQ_MASK_EN
        vecs.push_back('{0, 0, 4'b1010, -100, 0, -1, 13, "mask_1010"});
`endif

        repeat (2) @(negedge clk);
        check("reset_main", act(0), '0);
        check("reset_s0", act(1), '0);
        rst_n = 1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // start together with hold in IDLE is ignored
        @(negedge clk);
        start = 1; hold = 1;
        @(negedge clk);
        start = 0; hold = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_bit("start_hold_busy", busy, 1'b0);
            check_bit("start_hold_valid", ch_valid, 1'b0);
        end

        // async reset in the middle of channel C's dwell
        pulse_start(0);
        for (int k = 1; k <= 12; k++) @(negedge clk);
        check("pre_reset", act(0), out_t'({2'd2, 1'b1, 1'b1, 1'b0}));
        #2 rst_n = 0;
        #1 check("async_reset", act(0), '0);
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_reset_idle", act(0), '0);
        end

`ifdef SEL_SEQ_MASK_EN
        ch_mask = 4'h0;
        pulse_start(0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_bit("mask0_start", busy, 1'b0);
        end
        ch_mask = 4'hF;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
